// File: rtl/lsu_pkg.sv
// lsu_pkg: shared constants and types for the memory-stage load/store unit.
// Opcodes, funct3 access encodings, the LSU state enum and an alignment helper
// used when LSU_MISALIGN_CHECK_EN is defined.
package lsu_pkg;

  // Major opcodes recognised by the memory stage
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  // funct3 access encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Access size field (funct3[1:0]) values
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } lsu_state_e;

  // True when an access of the given size cannot be served from one aligned word lane group
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic mis;
    mis = 1'b0;
    case (size)
      SZ_HALF: mis = offset[0];
      SZ_WORD: mis = (offset != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_align.sv
// load_align: picks the addressed byte/halfword/word out of a read word and
// sign- or zero-extends it. Lanes shifted in from above byte 3 read as zero.
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] shifted;

  // Shift the addressed lane down to bit 0, then extend according to access type
  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    result  = shifted;
    case (funct3)
      F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    result = shifted;
      F3_BU:   result = {24'h000000, shifted[7:0]};
      F3_HU:   result = {16'h0000, shifted[15:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory stage of an in-order pipeline. Non-memory ops pass
// through with one cycle latency; loads/stores stall upstream while a single
// bus request is outstanding, with a wait-cycle timeout that raises bus_err.
// Optional feature macro: LSU_MISALIGN_CHECK_EN -- when defined, misaligned
// halfword/word accesses are rejected with a one-cycle misalign pulse instead
// of being issued to the bus.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_addr,
  input  logic [3:0]  in_wbyte,
  input  logic [31:0] in_wdata,
  input  logic        in_rwv,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        bus_err,
  output logic        misalign
);

  localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W   = (CNT_RAW < 4) ? 4 : CNT_RAW;
  // Last BUSY cycle index before the request is abandoned
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [3:0]       mem_wstrb_q, mem_wstrb_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;

  logic             wb_valid_q, wb_valid_d;
  logic [4:0]       wb_rd_q, wb_rd_d;
  logic [31:0]      wb_data_q, wb_data_d;
  logic             bus_err_q, bus_err_d;

  // Load context captured at issue so the held inputs need not be consulted in BUSY
  logic             op_rwv_q, op_rwv_d;
  logic [4:0]       op_rd_q, op_rd_d;
  logic [2:0]       op_funct3_q, op_funct3_d;
  logic [1:0]       op_offset_q, op_offset_d;

  logic             is_load, is_store, is_mem;
  logic             misaligned_c;
  logic             issue_c;
  logic             stall_c;
  logic [31:0]      load_result;

  assign is_load  = (in_opcode == OPC_LOAD);
  assign is_store = (in_opcode == OPC_STORE);
  assign is_mem   = is_load | is_store;

`ifdef LSU_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  assign misaligned_c = is_misaligned(in_funct3[1:0], in_addr[1:0]);

  // Rejected misaligned accesses produce a single-cycle pulse from IDLE
  always_comb begin
    misalign_d = (state_q == IDLE) && is_mem && misaligned_c;
  end

  // Misalign pulse register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign misalign = misalign_q;
`else
  assign misaligned_c = 1'b0;
  assign misalign     = 1'b0;
`endif

  assign issue_c = is_mem & ~misaligned_c;

  load_align u_load_align (
    .rdata  (mem_rdata),
    .offset (op_offset_q),
    .funct3 (op_funct3_q),
    .result (load_result)
  );

  // Next-state, bus request and writeback decisions
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wstrb_d = mem_wstrb_q;
    mem_wdata_d = mem_wdata_q;
    wb_valid_d  = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    bus_err_d   = 1'b0;
    op_rwv_d    = op_rwv_q;
    op_rd_d     = op_rd_q;
    op_funct3_d = op_funct3_q;
    op_offset_d = op_offset_q;
    stall_c     = 1'b0;

    case (state_q)
      IDLE: begin
        if (issue_c) begin
          stall_c     = 1'b1;
          state_d     = BUSY;
          cnt_d       = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = is_store;
          mem_addr_d  = {in_addr[31:2], 2'b00};
          mem_wstrb_d = is_store ? in_wbyte : 4'h0;
          mem_wdata_d = in_wdata;
          op_rwv_d    = in_rwv & is_load;
          op_rd_d     = in_rd;
          op_funct3_d = in_funct3;
          op_offset_d = in_addr[1:0];
        end else if (!is_mem) begin
          wb_valid_d = in_rwv;
          if (in_rwv) begin
            wb_rd_d   = in_rd;
            wb_data_d = in_rdata;
          end
        end
      end
      BUSY: begin
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          if (op_rwv_q) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = op_rd_q;
            wb_data_d  = load_result;
          end
        end else if (cnt_q == CNT_LAST) begin
          // Give up; stall drops now so upstream moves past the failed op
          state_d   = IDLE;
          mem_req_d = 1'b0;
          bus_err_d = 1'b1;
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers; asynchronous reset clears everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wstrb_q <= 4'h0;
      mem_wdata_q <= 32'h0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= 5'd0;
      wb_data_q   <= 32'h0;
      bus_err_q   <= 1'b0;
      op_rwv_q    <= 1'b0;
      op_rd_q     <= 5'd0;
      op_funct3_q <= 3'd0;
      op_offset_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_wdata_q <= mem_wdata_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      bus_err_q   <= bus_err_d;
      op_rwv_q    <= op_rwv_d;
      op_rd_q     <= op_rd_d;
      op_funct3_q <= op_funct3_d;
      op_offset_q <= op_offset_d;
    end
  end

  // Stall is forced low while reset is asserted
  assign stall     = rst_n & stall_c;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wstrb = mem_wstrb_q;
  assign mem_wdata = mem_wdata_q;
  assign wb_valid  = wb_valid_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed stimulus with a scoreboard; expected writeback,
// bus_err and misalign pulses are queued at issue and checked by a monitor.
// Honours LSU_MISALIGN_CHECK_EN the same way as the design.
module tb_mem_stage_lsu;

  localparam int K_WB   = 0;
  localparam int K_BERR = 1;
  localparam int K_MIS  = 2;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;

  typedef struct {
    int          kind;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  logic        clk, rst_n;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr, in_wdata, in_rdata;
  logic [3:0]  in_wbyte;
  logic        in_rwv;
  logic [4:0]  in_rd;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        stall, wb_valid, bus_err, misalign;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  int   mon_kind;

  mem_stage_lsu #(.TIMEOUT_CYCLES(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_opcode (in_opcode),
    .in_funct3 (in_funct3),
    .in_addr   (in_addr),
    .in_wbyte  (in_wbyte),
    .in_wdata  (in_wdata),
    .in_rwv    (in_rwv),
    .in_rd     (in_rd),
    .in_rdata  (in_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wstrb (mem_wstrb),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .stall     (stall),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .bus_err   (bus_err),
    .misalign  (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [4:0] rd, input logic [31:0] data);
    exp_t e;
    e.kind = kind;
    e.rd   = rd;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic drive_nop();
    in_opcode = OP_IMM;
    in_funct3 = 3'b000;
    in_addr   = 32'h0;
    in_wbyte  = 4'h0;
    in_wdata  = 32'h0;
    in_rwv    = 1'b0;
    in_rd     = 5'd0;
    in_rdata  = 32'h0;
  endtask

  task automatic drive_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [3:0] wbyte, input logic [31:0] wdata, input logic rwv,
                          input logic [4:0] rd, input logic [31:0] rdata);
    in_opcode = op;
    in_funct3 = f3;
    in_addr   = addr;
    in_wbyte  = wbyte;
    in_wdata  = wdata;
    in_rwv    = rwv;
    in_rd     = rd;
    in_rdata  = rdata;
  endtask

  // Pass-through op: one IDLE cycle with stall low
  task automatic pass_op(input logic [6:0] op, input logic rwv, input logic [4:0] rd, input logic [31:0] data);
    drive_op(op, 3'b000, 32'h0, 4'h0, 32'h0, rwv, rd, data);
    @(negedge clk);
    check("pass_stall", {31'b0, stall}, 32'd0);
    check("pass_no_req", {31'b0, mem_req}, 32'd0);
    @(posedge clk); #1;
    drive_nop();
  endtask

  // Memory op: issue, wait ack_wait BUSY cycles without ack, then ack
  task automatic mem_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [3:0] wbyte, input logic [31:0] wdata, input logic rwv,
                        input logic [4:0] rd, input int ack_wait, input logic [31:0] word,
                        input logic [31:0] exp_addr, input logic exp_we, input logic [3:0] exp_wstrb,
                        input int exp_stall);
    int nstall;
    nstall = 0;
    drive_op(op, f3, addr, wbyte, wdata, rwv, rd, 32'hDEAD0000);
    @(negedge clk);
    check("issue_stall", {31'b0, stall}, 32'd1);
    check("issue_no_req_yet", {31'b0, mem_req}, 32'd0);
    if (stall) nstall++;
    @(posedge clk); #1;
    for (int i = 0; i <= ack_wait; i++) begin
      if (i == ack_wait) begin
        mem_ack   = 1'b1;
        mem_rdata = word;
      end
      @(negedge clk);
      check("mem_req", {31'b0, mem_req}, 32'd1);
      check("mem_addr", mem_addr, exp_addr);
      check("mem_we", {31'b0, mem_we}, {31'b0, exp_we});
      check("mem_wstrb", {28'b0, mem_wstrb}, {28'b0, exp_wstrb});
      check("mem_wdata", mem_wdata, wdata);
      if (stall) nstall++;
      @(posedge clk); #1;
    end
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    drive_nop();
    check("stall_cycles", nstall, exp_stall);
  endtask

  // Scoreboard monitor: every output pulse must match the head of the queue
  always @(negedge clk) begin
    if (rst_n && (wb_valid || bus_err || misalign)) begin
      mon_kind = bus_err ? K_BERR : (misalign ? K_MIS : K_WB);
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse: got kind=%0d rd=%0d data=%08h, expected no pulse",
                 mon_kind, wb_rd, wb_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_kind != mon_e.kind || (wb_valid && (bus_err || misalign)) ||
            (mon_e.kind == K_WB && (wb_rd !== mon_e.rd || wb_data !== mon_e.data))) begin
          fails++;
          $display("FAIL pulse: got kind=%0d rd=%0d data=%08h, expected kind=%0d rd=%0d data=%08h",
                   mon_kind, wb_rd, wb_data, mon_e.kind, mon_e.rd, mon_e.data);
        end else begin
          $display("[TB] ok kind=%0d rd=%0d data=%08h", mon_kind, wb_rd, wb_data);
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    // A load presented during reset must not raise stall
    drive_op(OP_LOAD, 3'b010, 32'h40, 4'h0, 32'h0, 1'b1, 5'd1, 32'h0);
    repeat (2) @(negedge clk);
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    check("rst_wb_rd", {27'b0, wb_rd}, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_bus_err", {31'b0, bus_err}, 32'd0);
    check("rst_misalign", {31'b0, misalign}, 32'd0);
    @(posedge clk); #1;
    drive_nop();
    rst_n = 1'b1;

    // ADD pass-through
    push(K_WB, 5'd5, 32'h3);
    pass_op(OP_ALU, 1'b1, 5'd5, 32'h0000_0003);
    // pass-through without register write: no pulse expected
    pass_op(OP_ALU, 1'b0, 5'd6, 32'h1234_5678);

    // LB 0x103, ack two cycles after request
    push(K_WB, 5'd7, 32'hFFFF_FF80);
    mem_op(OP_LOAD, 3'b000, 32'h103, 4'h0, 32'h0, 1'b1, 5'd7, 2, 32'h80FF_FFFF,
           32'h100, 1'b0, 4'h0, 3);

    // SW 0x70: no writeback even with rwv set
    mem_op(OP_STORE, 3'b010, 32'h70, 4'hF, 32'h0C00_0000, 1'b1, 5'd8, 0, 32'h0,
           32'h70, 1'b1, 4'hF, 1);

    // Back-to-back loads of each extension type
    push(K_WB, 5'd3, 32'h0000_0056);
    mem_op(OP_LOAD, 3'b100, 32'h101, 4'h0, 32'h0, 1'b1, 5'd3, 0, 32'h1234_5678,
           32'h100, 1'b0, 4'h0, 1);
    push(K_WB, 5'd4, 32'hFFFF_8001);
    mem_op(OP_LOAD, 3'b001, 32'h102, 4'h0, 32'h0, 1'b1, 5'd4, 1, 32'h8001_1234,
           32'h100, 1'b0, 4'h0, 2);
    push(K_WB, 5'd12, 32'h0000_8001);
    mem_op(OP_LOAD, 3'b101, 32'h102, 4'h0, 32'h0, 1'b1, 5'd12, 0, 32'h8001_1234,
           32'h100, 1'b0, 4'h0, 1);
    push(K_WB, 5'd6, 32'hDEAD_BEEF);
    mem_op(OP_LOAD, 3'b010, 32'h104, 4'h0, 32'h0, 1'b1, 5'd6, 0, 32'hDEAD_BEEF,
           32'h104, 1'b0, 4'h0, 1);
    push(K_WB, 5'd13, 32'h0000_007F);
    mem_op(OP_LOAD, 3'b000, 32'h100, 4'h0, 32'h0, 1'b1, 5'd13, 0, 32'h0000_007F,
           32'h100, 1'b0, 4'h0, 1);

    // Timeout: 16 BUSY cycles with no ack, then a late ack is discarded
    drive_op(OP_LOAD, 3'b010, 32'h200, 4'h0, 32'h0, 1'b1, 5'd9, 32'h0);
    @(negedge clk);
    check("to_issue_stall", {31'b0, stall}, 32'd1);
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("to_mem_req", {31'b0, mem_req}, 32'd1);
      check("to_stall", {31'b0, stall}, (i == 15) ? 32'd0 : 32'd1);
      if (i == 15) push(K_BERR, 5'd0, 32'h0);
      @(posedge clk); #1;
    end
    drive_nop();
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check("to_req_dropped", {31'b0, mem_req}, 32'd0);
    check("to_stall_idle", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    check("late_ack_no_bus_err", {31'b0, bus_err}, 32'd0);
    check("late_ack_no_req", {31'b0, mem_req}, 32'd0);
    @(posedge clk); #1;

    // Misaligned LW 0x102
`ifdef LSU_MISALIGN_CHECK_EN
    drive_op(OP_LOAD, 3'b010, 32'h102, 4'h0, 32'h0, 1'b1, 5'd10, 32'h0);
    push(K_MIS, 5'd0, 32'h0);
    @(negedge clk);
    check("mis_stall", {31'b0, stall}, 32'd0);
    check("mis_no_req", {31'b0, mem_req}, 32'd0);
    @(posedge clk); #1;
    drive_nop();
    @(negedge clk);
    check("mis_no_req_after", {31'b0, mem_req}, 32'd0);
    @(posedge clk); #1;
`else
    push(K_WB, 5'd10, 32'h0000_AABB);
    mem_op(OP_LOAD, 3'b010, 32'h102, 4'h0, 32'h0, 1'b1, 5'd10, 0, 32'hAABB_CCDD,
           32'h100, 1'b0, 4'h0, 1);
`endif

    // Reset asserted mid-wait
    drive_op(OP_LOAD, 3'b010, 32'h300, 4'h0, 32'h0, 1'b1, 5'd11, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_rst_busy_req", {31'b0, mem_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_mem_req", {31'b0, mem_req}, 32'd0);
    check("arst_mem_addr", mem_addr, 32'd0);
    check("arst_stall", {31'b0, stall}, 32'd0);
    check("arst_wb_rd", {27'b0, wb_rd}, 32'd0);
    check("arst_wb_data", wb_data, 32'd0);
    @(posedge clk); #1;
    drive_nop();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_no_req", {31'b0, mem_req}, 32'd0);
    @(posedge clk); #1;
    push(K_WB, 5'd11, 32'h0000_0055);
    pass_op(OP_ALU, 1'b1, 5'd11, 32'h0000_0055);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
